// File: rtl/imem_loadable_if.sv
// Fetch and program-load signal bundle for imem_loadable.
// master: the fetch stage / program loader; slave: the instruction memory.
interface imem_loadable_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int PC_W   = 16
) ();
    logic [PC_W-1:0]   pc;
    logic              fetch_en;
    logic [DATA_W-1:0] op;
    logic              op_valid;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              busy;
    logic              ld_ovf;
    logic              pc_oob;

    modport master (
        output pc, fetch_en, ld_start, ld_valid, ld_data, ld_last,
        input  op, op_valid, ld_ready, ld_count, busy, ld_ovf, pc_oob
    );

    modport slave (
        input  pc, fetch_en, ld_start, ld_valid, ld_data, ld_last,
        output op, op_valid, ld_ready, ld_count, busy, ld_ovf, pc_oob
    );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory for the fetch stage.
// Sequence: CLEAR sweeps every word to NOP_WORD, LOAD takes a program stream
// from address 0, RUN serves 1-cycle-latency fetches until ld_start.
// The array is a single-port RAM with registered read; CLEAR/LOAD own the
// port for writes, RUN owns it for reads, so the two never collide.
module imem_loadable #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter int                PC_W     = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input logic            clk,
    input logic            rst,
    imem_loadable_if.slave bus
);
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W:0]   ld_count;
    logic              ld_ovf;
    logic              pc_oob;
    logic              ld_ready;
    logic              busy;

    // Fetch pipeline stage p1: read data plus its valid and out-of-range tag
    logic              vld_p1;
    logic              oob_p1;
    logic [DATA_W-1:0] rd_data_p1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;
    logic              pc_hi;
    logic              ld_accept;

    // Upper PC bits only exist when the PC is wider than the word address
    generate
        if (PC_W > ADDR_W) begin : g_pc_hi
            assign pc_hi = |bus.pc[PC_W-1:ADDR_W];
        end else begin : g_no_pc_hi
            assign pc_hi = 1'b0;
        end
    endgenerate

    assign ld_accept = (state == S_LOAD) && bus.ld_valid;

    // Single RAM port: address/write source chosen by the current phase
    always_comb begin
        mem_addr  = bus.pc[ADDR_W-1:0];
        mem_we    = 1'b0;
        mem_wdata = NOP_WORD;
        rd_en     = 1'b0;
        unique case (state)
            S_CLEAR: begin
                mem_addr = clr_ptr;
                mem_we   = 1'b1;
            end
            S_LOAD: begin
                mem_addr  = ld_ptr;
                mem_we    = bus.ld_valid;
                mem_wdata = bus.ld_data;
            end
            S_RUN: begin
                rd_en = bus.fetch_en && !bus.ld_start && !pc_hi;
            end
            default: ;
        endcase
    end

    // RAM array with registered read; data path carries no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_p1 <= mem[mem_addr];
        end
    end

    // Control FSM: phase sequencing, load pointers, sticky flags, fetch valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_ptr  <= '0;
            ld_ptr   <= '0;
            ld_count <= '0;
            ld_ovf   <= 1'b0;
            pc_oob   <= 1'b0;
            ld_ready <= 1'b0;
            busy     <= 1'b1;
            vld_p1   <= 1'b0;
            oob_p1   <= 1'b0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    vld_p1  <= 1'b0;
                    oob_p1  <= 1'b0;
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_ADDR) begin
                        state    <= S_LOAD;
                        ld_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    vld_p1 <= 1'b0;
                    oob_p1 <= 1'b0;
                    if (ld_accept) begin
                        if (ld_count != CNT_MAX) begin
                            ld_count <= ld_count + 1'b1;
                        end
                        // Pointer parks on the last word instead of wrapping
                        if (ld_ptr != LAST_ADDR) begin
                            ld_ptr <= ld_ptr + 1'b1;
                        end
                        if (bus.ld_last || ld_ptr == LAST_ADDR) begin
                            state    <= S_RUN;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                            ld_ovf   <= !bus.ld_last;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.ld_start) begin
                        // Reload wins over a same-cycle fetch
                        state    <= S_LOAD;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                        ld_ptr   <= '0;
                        ld_count <= '0;
                        ld_ovf   <= 1'b0;
                        pc_oob   <= 1'b0;
                        vld_p1   <= 1'b0;
                        oob_p1   <= 1'b0;
                    end else begin
                        vld_p1 <= bus.fetch_en;
                        oob_p1 <= bus.fetch_en && pc_hi;
                        if (bus.fetch_en && pc_hi) begin
                            pc_oob <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    assign bus.op       = (vld_p1 && !oob_p1) ? rd_data_p1 : NOP_WORD;
    assign bus.op_valid = vld_p1;
    assign bus.ld_ready = ld_ready;
    assign bus.ld_count = ld_count;
    assign bus.busy     = busy;
    assign bus.ld_ovf   = ld_ovf;
    assign bus.pc_oob   = pc_oob;
endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: a 16-word instance for the sweep, load,
// overflow, reload and reset sequences, and a 4096-word instance for the
// out-of-range PC case.
module tb_imem_loadable;
    logic clk = 1'b0;
    logic rst4 = 1'b0;
    logic rst12 = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    imem_loadable_if #(.DATA_W(16), .ADDR_W(4),  .PC_W(16)) b4 ();
    imem_loadable_if #(.DATA_W(16), .ADDR_W(12), .PC_W(16)) b12 ();

    imem_loadable #(.DATA_W(16), .ADDR_W(4), .PC_W(16), .NOP_WORD(16'h0000)) dut4 (
        .clk(clk), .rst(rst4), .bus(b4.slave)
    );
    imem_loadable #(.DATA_W(16), .ADDR_W(12), .PC_W(16), .NOP_WORD(16'h0000)) dut12 (
        .clk(clk), .rst(rst12), .bus(b12.slave)
    );

    typedef struct {
        logic [15:0] pc;
        logic        fe;
        logic        ev;
        logic [15:0] eop;
    } fvec_t;

    fvec_t vt [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic ld4(input logic [15:0] d, input logic last, input logic v);
        b4.ld_data  = d;
        b4.ld_last  = last;
        b4.ld_valid = v;
        @(negedge clk);
        b4.ld_valid = 1'b0;
        b4.ld_last  = 1'b0;
    endtask

    task automatic run_fetch(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            b4.pc       = vt[i].pc;
            b4.fetch_en = vt[i].fe;
            @(negedge clk);
            check($sformatf("fetch[%0d].op_valid", i), 32'(b4.op_valid), 32'(vt[i].ev));
            check($sformatf("fetch[%0d].op", i), 32'(b4.op), 32'(vt[i].eop));
        end
        b4.fetch_en = 1'b0;
    endtask

    task automatic sweep4(input string name);
        int n;
        int seen_valid;
        n = 0;
        seen_valid = 0;
        b4.fetch_en = 1'b1;
        b4.pc = 16'h0000;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n++;
            if (b4.op_valid) seen_valid++;
            if (b4.ld_ready) break;
        end
        check({name, " sweep cycles"}, 32'(n), 32'd16);
        check({name, " op_valid during sweep"}, 32'(seen_valid), 32'd0);
        check({name, " busy in LOAD"}, 32'(b4.busy), 32'd1);
        b4.fetch_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // T2 fetch: pc 0..6, disabled fetch, out-of-range pc
        for (int i = 0; i < 5; i++) vt[i] = '{16'(i), 1'b1, 1'b1, 16'hA000 + 16'(i)};
        vt[5]  = '{16'd5,   1'b1, 1'b1, 16'h0000};
        vt[6]  = '{16'd6,   1'b1, 1'b1, 16'h0000};
        vt[7]  = '{16'd2,   1'b0, 1'b0, 16'h0000};
        vt[8]  = '{16'h0010, 1'b1, 1'b1, 16'h0000};
        // T3 fetch: new words over old program tail
        vt[9]  = '{16'd0, 1'b1, 1'b1, 16'hB000};
        vt[10] = '{16'd1, 1'b1, 1'b1, 16'hB001};
        vt[11] = '{16'd2, 1'b1, 1'b1, 16'hB002};
        vt[12] = '{16'd3, 1'b1, 1'b1, 16'hA003};
        vt[13] = '{16'd4, 1'b1, 1'b1, 16'hA004};
        // T4 fetch: full program, 17th word dropped
        vt[14] = '{16'd0,  1'b1, 1'b1, 16'hC000};
        vt[15] = '{16'd15, 1'b1, 1'b1, 16'hC00F};
        // after reset re-sweep
        vt[16] = '{16'd0, 1'b1, 1'b1, 16'hD000};
        vt[17] = '{16'd1, 1'b1, 1'b1, 16'h0000};

        b4.pc = '0; b4.fetch_en = 1'b0; b4.ld_start = 1'b0;
        b4.ld_valid = 1'b0; b4.ld_data = '0; b4.ld_last = 1'b0;
        b12.pc = '0; b12.fetch_en = 1'b0; b12.ld_start = 1'b0;
        b12.ld_valid = 1'b0; b12.ld_data = '0; b12.ld_last = 1'b0;

        // T1: reset values and sweep length
        #1;
        rst4 = 1'b1;
        rst12 = 1'b1;
        #1;
        check("rst busy", 32'(b4.busy), 32'd1);
        check("rst ld_ready", 32'(b4.ld_ready), 32'd0);
        check("rst op_valid", 32'(b4.op_valid), 32'd0);
        check("rst op", 32'(b4.op), 32'h0000);
        check("rst ld_count", 32'(b4.ld_count), 32'd0);
        check("rst ld_ovf", 32'(b4.ld_ovf), 32'd0);
        check("rst pc_oob", 32'(b4.pc_oob), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        sweep4("T1");

        // T2: five-word program, fetch in LOAD ignored
        b4.fetch_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld4(16'hA000 + 16'(i), i == 4, 1'b1);
            if (i == 0) check("T2 op_valid in LOAD", 32'(b4.op_valid), 32'd0);
        end
        b4.fetch_en = 1'b0;
        check("T2 busy", 32'(b4.busy), 32'd0);
        check("T2 ld_ready", 32'(b4.ld_ready), 32'd0);
        check("T2 ld_count", 32'(b4.ld_count), 32'd5);
        check("T2 ld_ovf", 32'(b4.ld_ovf), 32'd0);
        check("T2 pc_oob before", 32'(b4.pc_oob), 32'd0);
        run_fetch(0, 8);
        check("T2 pc_oob after", 32'(b4.pc_oob), 32'd1);

        // T3: reload with gaps; junk on ld_data during gaps
        b4.ld_start = 1'b1;
        @(negedge clk);
        b4.ld_start = 1'b0;
        check("T3 ld_ready", 32'(b4.ld_ready), 32'd1);
        check("T3 ld_count cleared", 32'(b4.ld_count), 32'd0);
        check("T3 pc_oob cleared", 32'(b4.pc_oob), 32'd0);
        ld4(16'hB000, 1'b0, 1'b1);
        ld4(16'hDEAD, 1'b0, 1'b0);
        ld4(16'hBEEF, 1'b1, 1'b0);
        ld4(16'hB001, 1'b0, 1'b1);
        ld4(16'hB002, 1'b1, 1'b1);
        check("T3 busy", 32'(b4.busy), 32'd0);
        check("T3 ld_count", 32'(b4.ld_count), 32'd3);
        run_fetch(9, 13);

        // T6a: ld_start beats fetch_en
        b4.ld_start = 1'b1;
        b4.fetch_en = 1'b1;
        b4.pc = 16'd0;
        @(negedge clk);
        b4.ld_start = 1'b0;
        check("T6 op_valid after ld_start", 32'(b4.op_valid), 32'd0);
        check("T6 ld_ready after ld_start", 32'(b4.ld_ready), 32'd1);
        @(negedge clk);
        check("T6 op_valid in LOAD", 32'(b4.op_valid), 32'd0);
        b4.fetch_en = 1'b0;

        // T4: sixteen words without last forces the end
        for (int i = 0; i < 16; i++) begin
            ld4(16'hC000 + 16'(i), 1'b0, 1'b1);
            if (i == 14) check("T4 busy before 16th", 32'(b4.busy), 32'd1);
        end
        check("T4 ld_ovf", 32'(b4.ld_ovf), 32'd1);
        check("T4 busy", 32'(b4.busy), 32'd0);
        check("T4 ld_count", 32'(b4.ld_count), 32'd16);
        ld4(16'hEEEE, 1'b1, 1'b1);
        check("T4 17th ld_count", 32'(b4.ld_count), 32'd16);
        check("T4 17th ld_ready", 32'(b4.ld_ready), 32'd0);
        run_fetch(14, 15);
        check("T4 ld_ovf sticky", 32'(b4.ld_ovf), 32'd1);
        b4.ld_start = 1'b1;
        @(negedge clk);
        b4.ld_start = 1'b0;
        check("T4 ld_ovf cleared", 32'(b4.ld_ovf), 32'd0);

        // T6b: asynchronous reset in the middle of a load
        ld4(16'hF000, 1'b0, 1'b1);
        ld4(16'hF001, 1'b0, 1'b1);
        check("T6 mid-load ld_count", 32'(b4.ld_count), 32'd2);
        #2;
        rst4 = 1'b1;
        #1;
        check("T6 rst busy", 32'(b4.busy), 32'd1);
        check("T6 rst op_valid", 32'(b4.op_valid), 32'd0);
        check("T6 rst ld_ready", 32'(b4.ld_ready), 32'd0);
        check("T6 rst ld_count", 32'(b4.ld_count), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        sweep4("T6");
        ld4(16'hD000, 1'b1, 1'b1);
        run_fetch(16, 17);

        // T5: out-of-range pc on the 4096-word instance
        @(negedge clk);
        rst12 = 1'b0;
        n = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            n++;
            if (b12.ld_ready) break;
        end
        check("T5 sweep cycles", 32'(n), 32'd4096);
        b12.ld_data = 16'h1234;
        b12.ld_last = 1'b1;
        b12.ld_valid = 1'b1;
        @(negedge clk);
        b12.ld_valid = 1'b0;
        b12.ld_last = 1'b0;
        check("T5 busy", 32'(b12.busy), 32'd0);
        b12.pc = 16'h1003;
        b12.fetch_en = 1'b1;
        @(negedge clk);
        check("T5 oob op", 32'(b12.op), 32'h0000);
        check("T5 oob op_valid", 32'(b12.op_valid), 32'd1);
        check("T5 pc_oob", 32'(b12.pc_oob), 32'd1);
        b12.pc = 16'h0000;
        @(negedge clk);
        b12.fetch_en = 1'b0;
        check("T5 in-range op", 32'(b12.op), 32'h1234);
        check("T5 pc_oob sticky", 32'(b12.pc_oob), 32'd1);
        b12.ld_start = 1'b1;
        @(negedge clk);
        b12.ld_start = 1'b0;
        check("T5 pc_oob cleared", 32'(b12.pc_oob), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
